// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with occupancy count, programmable almost_full/almost_empty
// thresholds and sticky overflow/underflow error flags.
//
// Optional feature: define FIFO_FWFT_EN for first-word fall-through. In that mode rdata shows the
// head word combinationally while the FIFO is not empty. Without it, reads use a registered
// 1-cycle path: rdata updates on an accepted read and holds its value otherwise.
//
// Ports:
//   clk1          clock, all logic on the posedge
//   rst1          synchronous active-high reset
//   w_en, wdata   write request and write data
//   r_en          read request (a pop in FWFT mode)
//   clr_err       clears overflow/underflow; a new error event in the same cycle wins
//   rdata         read data
//   full, empty   count == DEPTH, count == 0
//   almost_full   count >= AF_LEVEL
//   almost_empty  count <= AE_LEVEL
//   count         occupancy, 0..DEPTH
//   overflow      sticky: a write was attempted while full
//   underflow     sticky: a read was attempted while empty
module sync_fifo_flags #(
  parameter int unsigned datasize = 8,
  parameter int unsigned addrsize = 4,
  parameter int unsigned AF_LEVEL = 12,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                clk1,
  input  logic                rst1,
  input  logic                w_en,
  input  logic [datasize-1:0] wdata,
  input  logic                r_en,
  input  logic                clr_err,
  output logic [datasize-1:0] rdata,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [addrsize:0]   count,
  output logic                overflow,
  output logic                underflow
);

  localparam int unsigned Depth = 1 << addrsize;
  localparam logic [addrsize:0] DepthCnt = (addrsize + 1)'(Depth);
  localparam logic [addrsize:0] AfCnt    = (addrsize + 1)'(AF_LEVEL);
  localparam logic [addrsize:0] AeCnt    = (addrsize + 1)'(AE_LEVEL);

  if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= Depth))) begin : gen_bad_levels
    $error("sync_fifo_flags: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [datasize-1:0] mem [Depth];

  logic [addrsize-1:0] wptr_q, wptr_d;
  logic [addrsize-1:0] rptr_q, rptr_d;
  logic [addrsize:0]   count_q, count_d;
  logic                full_q, empty_q, afull_q, aempty_q;
  logic                ovf_q, ovf_d, unf_q, unf_d;
  logic                wr_ok, rd_ok;

  // Accept decisions use the registered flags present at the edge.
  assign wr_ok = w_en & ~full_q;
  assign rd_ok = r_en & ~empty_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_ok) wptr_d = wptr_q + 1'b1;
    if (rd_ok) rptr_d = rptr_q + 1'b1;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Set takes priority over clear.
    ovf_d = (ovf_q & ~clr_err) | (w_en & full_q);
    unf_d = (unf_q & ~clr_err) | (r_en & empty_q);
  end

  always_ff @(posedge clk1) begin
    if (rst1) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == DepthCnt);
      empty_q  <= (count_d == '0);
      afull_q  <= (count_d >= AfCnt);
      aempty_q <= (count_d <= AeCnt);
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is not reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk1) begin
    if (wr_ok && !rst1) mem[wptr_q] <= wdata;
  end

`ifdef FIFO_FWFT_EN
  // Head word is visible whenever the FIFO holds data; don't-care while empty.
  assign rdata = mem[rptr_q];
`else
  logic [datasize-1:0] rdata_q;

  always_ff @(posedge clk1) begin
    if (rst1) begin
      rdata_q <= '0;
    end else if (rd_ok) begin
      rdata_q <= mem[rptr_q];
    end
  end

  assign rdata = rdata_q;
`endif

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed self-checking bench for sync_fifo_flags (datasize=8, addrsize=4, AF=12, AE=2).
module tb_sync_fifo_flags;

  logic       clk1 = 1'b0;
  logic       rst1, w_en, r_en, clr_err;
  logic [7:0] wdata, rdata;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk1 = ~clk1;

  sync_fifo_flags #(
    .datasize(8),
    .addrsize(4),
    .AF_LEVEL(12),
    .AE_LEVEL(2)
  ) dut (
    .clk1        (clk1),
    .rst1        (rst1),
    .w_en        (w_en),
    .wdata       (wdata),
    .r_en        (r_en),
    .clr_err     (clr_err),
    .rdata       (rdata),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  // Check the word a read returns: before the edge in FWFT mode, after it otherwise.
  task automatic read_word(input string tag, input logic [7:0] exp);
    r_en = 1'b1;
`ifdef FIFO_FWFT_EN
    check(tag, 32'(rdata), 32'(exp));
    tick();
`else
    tick();
    check(tag, 32'(rdata), 32'(exp));
`endif
    r_en = 1'b0;
  endtask

  initial begin
    rst1 = 1'b1; w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0; wdata = '0;

    // 1: reset
    tick(); tick();
    rst1 = 1'b0;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_aempty", 32'(almost_empty), 32'd1);
    check("rst_afull", 32'(almost_full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_unf", 32'(underflow), 32'd0);
`ifndef FIFO_FWFT_EN
    check("rst_rdata", 32'(rdata), 32'h00);
`endif

    // 2: fill 0x00..0x0F, then overflow
    for (int i = 0; i < 16; i++) begin
      w_en = 1'b1; wdata = 8'(i);
      tick();
      check("fill_count", 32'(count), 32'(i + 1));
      check("fill_aempty", 32'(almost_empty), 32'((i + 1) <= 2));
      check("fill_afull", 32'(almost_full), 32'((i + 1) >= 12));
      check("fill_full", 32'(full), 32'((i + 1) == 16));
    end
    wdata = 8'hAA;
    tick();
    w_en = 1'b0;
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd16);

    // 3: drain in order, then underflow, then clear
    for (int i = 0; i < 16; i++) begin
      read_word("drain_data", 8'(i));
      check("drain_count", 32'(count), 32'(15 - i));
    end
    check("drain_empty", 32'(empty), 32'd1);
    r_en = 1'b1;
    tick();
    r_en = 1'b0;
    check("unf_set", 32'(underflow), 32'd1);
    check("unf_count", 32'(count), 32'd0);
`ifndef FIFO_FWFT_EN
    check("unf_rdata_hold", 32'(rdata), 32'h0F);
`endif
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_unf", 32'(underflow), 32'd0);

    // 4: prefill 5, then 20 simultaneous read+write cycles across the pointer wrap
    for (int i = 0; i < 5; i++) begin
      w_en = 1'b1; wdata = 8'(8'h10 + i);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      w_en = 1'b1; wdata = 8'(8'h15 + i);
      read_word("rw_data", 8'(8'h10 + i));
      check("rw_count", 32'(count), 32'd5);
      check("rw_flags", 32'({full, empty, almost_full, almost_empty, overflow, underflow}), 32'd0);
    end
    w_en = 1'b0;
    for (int i = 0; i < 5; i++) read_word("rw_tail", 8'(8'h24 + i));
    check("rw_empty", 32'(empty), 32'd1);

    // 5: full plus simultaneous read+write -> read accepted, write dropped
    for (int i = 0; i < 16; i++) begin
      w_en = 1'b1; wdata = 8'(8'h30 + i);
      tick();
    end
    w_en = 1'b1; wdata = 8'hEE;
    read_word("fullrw_data", 8'h30);
    w_en = 1'b0;
    check("fullrw_count", 32'(count), 32'd15);
    check("fullrw_ovf", 32'(overflow), 32'd1);
    check("fullrw_full", 32'(full), 32'd0);
    for (int i = 1; i < 16; i++) read_word("fullrw_drain", 8'(8'h30 + i));
    check("fullrw_empty", 32'(empty), 32'd1);
    check("fullrw_unf", 32'(underflow), 32'd0);

    // 6: reset mid-operation at count=7
    for (int i = 0; i < 7; i++) begin
      w_en = 1'b1; wdata = 8'(8'h60 + i);
      tick();
    end
    w_en = 1'b0;
    check("pre_rst_count", 32'(count), 32'd7);
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    w_en = 1'b1; wdata = 8'h5A;
    tick();
    w_en = 1'b0;
    check("post_rst_count", 32'(count), 32'd1);
    check("post_rst_empty", 32'(empty), 32'd0);
`ifdef FIFO_FWFT_EN
    check("post_rst_fwft", 32'(rdata), 32'h5A);
`endif
    read_word("post_rst_data", 8'h5A);
    check("post_rst_final_empty", 32'(empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
